trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_pkg.sv | 21 ++
 rtl/trap_ctrl_stat.sv | 44 ++++
 rtl/trap_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg -- shared definitions for the trap/redirect controller.
//   INST_ADDR_BUS    : instruction address width (64)
//   MTVEC_ALIGN_MASK : clears mtvec mode bits [1:0] to form a direct-mode target
//   trap_state_e     : controller state encoding (IDLE / FLUSH / REDIRECT)
//   FLUSH_CNT_W      : width of the flush down-counter (FLUSH_LEN up to 15)
//   STAT_W           : width of the optional event counters
package trap_ctrl_pkg;

  localparam int INST_ADDR_BUS = 64;
  localparam int FLUSH_CNT_W   = 4;
  localparam int STAT_W        = 32;

  localparam logic [INST_ADDR_BUS-1:0] MTVEC_ALIGN_MASK = ~64'h3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_e;

endpackage

// File: rtl/trap_ctrl_stat.sv
// trap_ctrl_stat -- free-running event counters for the trap controller.
// Counts taken exceptions (ecall/ebreak) and taken interrupts; both wrap
// from 0xFFFFFFFF to 0.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   trap_evt_i    : one-cycle pulse per exception taken
//   intp_evt_i    : one-cycle pulse per interrupt taken
//   trap_cnt_o    : exception count
//   intp_cnt_o    : interrupt count
module trap_ctrl_stat
  import trap_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_evt_i,
  input  logic              intp_evt_i,
  output logic [STAT_W-1:0] trap_cnt_o,
  output logic [STAT_W-1:0] intp_cnt_o
);

  logic [STAT_W-1:0] trap_cnt_q, trap_cnt_d;
  logic [STAT_W-1:0] intp_cnt_q, intp_cnt_d;

  always_comb begin
    trap_cnt_d = trap_cnt_q;
    intp_cnt_d = intp_cnt_q;
    if (trap_evt_i) trap_cnt_d = trap_cnt_q + STAT_W'(1);
    if (intp_evt_i) intp_cnt_d = intp_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_cnt_q <= '0;
      intp_cnt_q <= '0;
    end else begin
      trap_cnt_q <= trap_cnt_d;
      intp_cnt_q <= intp_cnt_d;
    end
  end

  assign trap_cnt_o = trap_cnt_q;
  assign intp_cnt_o = intp_cnt_q;

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl -- MEM-stage trap/interrupt/mret controller.
// Recognises an interrupt, ecall/ebreak or mret on a committing MEM-stage
// instruction, flushes the front of the pipe for FLUSH_LEN cycles, then
// issues a valid/ready fetch redirect to the latched target.
// Optional build macro: TRAP_CTRL_STAT_EN adds trap_cnt_o / intp_cnt_o.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   mem_valid_i, mem_stall_i  : MEM-stage instruction valid / stalled
//   ecall_i, ebreak_i, mret_i : decoded MEM-stage instruction type
//   csr_trap_i                : interrupt pending from the CSR unit
//   mtvec_i, mepc_i           : current CSR values
//   intp_en_o, inst_trap_o,
//   mret_en_o                 : one-cycle event strobes to the CSR unit
//   hold_o, flush_o           : pipeline hold / front-end kill
//   redirect_valid_o,
//   redirect_ready_i,
//   redirect_pc_o             : fetch redirect handshake and target
//   trap_cnt_o, intp_cnt_o    : event counters (TRAP_CTRL_STAT_EN only)
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int FLUSH_LEN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_valid_i,
  input  logic                     mem_stall_i,
  input  logic                     ecall_i,
  input  logic                     ebreak_i,
  input  logic                     mret_i,
  input  logic                     csr_trap_i,
  input  logic [INST_ADDR_BUS-1:0] mtvec_i,
  input  logic [INST_ADDR_BUS-1:0] mepc_i,
  output logic                     intp_en_o,
  output logic                     inst_trap_o,
  output logic                     mret_en_o,
  output logic                     hold_o,
  output logic                     flush_o,
  output logic                     redirect_valid_o,
  input  logic                     redirect_ready_i,
  output logic [INST_ADDR_BUS-1:0] redirect_pc_o
`ifdef TRAP_CTRL_STAT_EN
  ,
  output logic [STAT_W-1:0]        trap_cnt_o,
  output logic [STAT_W-1:0]        intp_cnt_o
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_LEN - 1);

  trap_state_e              state_q, state_d;
  logic [FLUSH_CNT_W-1:0]   cnt_q, cnt_d;
  logic [INST_ADDR_BUS-1:0] pc_q, pc_d;
  logic                     commit_ok;
  logic                     take_event;

  // An event strobe during a reset cycle would reach the CSR unit while the
  // controller itself discards it, so reset suppresses recognition.
  assign commit_ok = mem_valid_i & ~mem_stall_i & ~rst;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    pc_d             = pc_q;
    take_event       = 1'b0;
    intp_en_o        = 1'b0;
    inst_trap_o      = 1'b0;
    mret_en_o        = 1'b0;
    hold_o           = 1'b0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (commit_ok) begin
          // Priority: interrupt, then ecall/ebreak, then mret.
          if (csr_trap_i) begin
            intp_en_o  = 1'b1;
            take_event = 1'b1;
            pc_d       = mtvec_i & MTVEC_ALIGN_MASK;
          end else if (ecall_i | ebreak_i) begin
            inst_trap_o = 1'b1;
            take_event  = 1'b1;
            pc_d        = mtvec_i & MTVEC_ALIGN_MASK;
          end else if (mret_i) begin
            mret_en_o  = 1'b1;
            take_event = 1'b1;
            pc_d       = mepc_i;
          end
        end
        if (take_event) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LAST;
        end
      end

      ST_FLUSH: begin
        flush_o = 1'b1;
        hold_o  = 1'b1;
        if (cnt_q == '0) state_d = ST_REDIRECT;
        else             cnt_d   = cnt_q - FLUSH_CNT_W'(1);
      end

      ST_REDIRECT: begin
        redirect_valid_o = 1'b1;
        hold_o           = 1'b1;
        if (redirect_ready_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  assign redirect_pc_o = pc_q;

`ifdef TRAP_CTRL_STAT_EN
  trap_ctrl_stat u_stat (
    .clk        (clk),
    .rst        (rst),
    .trap_evt_i (inst_trap_o),
    .intp_evt_i (intp_en_o),
    .trap_cnt_o (trap_cnt_o),
    .intp_cnt_o (intp_cnt_o)
  );
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
